uart_baud_sched: RTL and testbench

Baud-timing controller for the UART. Owns one prescaler, shared by TX and RX, that produces a 16x oversample tick. Derives a phase-alignable TX bit tick from it. Sequences runtime divisor reconfiguration so that a new divisor is applied only when neither the transmitter nor the receiver is mid-frame. Sits between the register/config interface and the TX/RX engines; it replaces free-running clock division with tick enables in the i_clk domain.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tick_gen.sv | 54 +++++
 rtl/uart_baud_sched.sv | 82 ++++++++
 tb/tb_uart_baud_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART baud-timing constants and config FSM state encoding.
// Pure definitions: no latency or backpressure of its own.
package uart_pkg;

   localparam int UART_DIV_W       = 16;
   localparam int UART_OS_RATE     = 16;
   localparam int UART_DEFAULT_DIV = 27;  // 50 MHz / (115200 * 16)

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_APPLY = 2'd2
   } cfg_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// Prescaler + TX bit-phase counter; os/tx ticks registered one cycle after the wrap edge.
// No backpressure: i_clr or !i_en zeroes both counters and suppresses ticks that cycle.
module uart_tick_gen
   import uart_pkg::*;
#(
   parameter int P_DIV_W   = UART_DIV_W,
   parameter int P_OS_RATE = UART_OS_RATE
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_clr,
   input  logic               i_sync,
   input  logic [P_DIV_W-1:0] i_div,
   output logic               o_os_tick,
   output logic               o_tx_tick
);

   localparam int PH_W = $clog2(P_OS_RATE);

   logic [P_DIV_W-1:0] cnt;
   logic [P_DIV_W-1:0] div_m1;
   logic [PH_W-1:0]    phase;
   logic               wrap;

   assign div_m1 = i_div - {{(P_DIV_W-1){1'b0}}, 1'b1};
   assign wrap   = (cnt == div_m1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt       <= '0;
         phase     <= '0;
         o_os_tick <= 1'b0;
         o_tx_tick <= 1'b0;
      end else if (i_clr || !i_en) begin
         cnt       <= '0;
         phase     <= '0;
         o_os_tick <= 1'b0;
         o_tx_tick <= 1'b0;
      end else begin
         o_os_tick <= wrap;
         o_tx_tick <= 1'b0;
         cnt       <= wrap ? '0 : cnt + 1'b1;
         // Sync wins over a coincident wrap: phase restarts at 0 and the bit tick is dropped.
         if (i_sync) begin
            phase <= '0;
         end else if (wrap) begin
            phase     <= phase + 1'b1;
            o_tx_tick <= (phase == PH_W'(P_OS_RATE - 1));
         end
      end
   end

endmodule

// File: rtl/uart_baud_sched.sv
// Baud scheduler: shared os tick, TX bit tick, divisor change applied 2 cycles after accept when idle.
// Backpressure: o_cfg_ready low while a request waits for TX and RX to leave their frames.
module uart_baud_sched
   import uart_pkg::*;
#(
   parameter int P_DIV_W       = UART_DIV_W,
   parameter int P_DEFAULT_DIV = UART_DEFAULT_DIV,
   parameter int P_OS_RATE     = UART_OS_RATE
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic [P_DIV_W-1:0] i_cfg_div,
   input  logic               i_cfg_valid,
   output logic               o_cfg_ready,
   output logic               o_cfg_done,
   output logic               o_cfg_err,
   input  logic               i_tx_busy,
   input  logic               i_rx_busy,
   input  logic               i_tx_sync,
   output logic               o_os_tick,
   output logic               o_tx_tick,
   output logic [P_DIV_W-1:0] o_div
);

   cfg_state_t         state;
   logic [P_DIV_W-1:0] r_div;
   logic [P_DIV_W-1:0] r_div_pend;

   assign o_cfg_ready = (state == ST_IDLE);
   assign o_div       = r_div;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         r_div      <= P_DIV_W'(P_DEFAULT_DIV);
         r_div_pend <= P_DIV_W'(P_DEFAULT_DIV);
         o_cfg_done <= 1'b0;
         o_cfg_err  <= 1'b0;
      end else begin
         o_cfg_done <= 1'b0;
         o_cfg_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_cfg_valid) begin
                  if (i_cfg_div < P_DIV_W'(2)) begin
                     o_cfg_err <= 1'b1;
                  end else begin
                     r_div_pend <= i_cfg_div;
                     state      <= ST_PEND;
                  end
               end
            end
            ST_PEND: begin
               if (!i_tx_busy && !i_rx_busy) state <= ST_APPLY;
            end
            ST_APPLY: begin
               r_div      <= r_div_pend;
               o_cfg_done <= 1'b1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The APPLY cycle clears prescaler and phase so the new rate starts from a clean edge.
   uart_tick_gen #(
      .P_DIV_W   (P_DIV_W),
      .P_OS_RATE (P_OS_RATE)
   ) u_tick_gen (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en),
      .i_clr     (state == ST_APPLY),
      .i_sync    (i_tx_sync),
      .i_div     (r_div),
      .o_os_tick (o_os_tick),
      .o_tx_tick (o_tx_tick)
   );

endmodule

// File: tb/tb_uart_baud_sched.sv
// Bench for uart_baud_sched: directed + random stimulus against a cycle-count reference model.
module tb_uart_baud_sched;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b1;
   logic        i_en = 1'b0;
   logic [15:0] i_cfg_div = '0;
   logic        i_cfg_valid = 1'b0;
   logic        i_tx_busy = 1'b0;
   logic        i_rx_busy = 1'b0;
   logic        i_tx_sync = 1'b0;
   logic        o_cfg_ready, o_cfg_done, o_cfg_err, o_os_tick, o_tx_tick;
   logic [15:0] o_div;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // Reference model: time measured in cycles since the prescaler restarted and in
   // oversample ticks since the TX phase restarted.
   int unsigned m_div = 27;
   int unsigned m_pend_div = 0;
   int unsigned m_elapsed = 0;
   int unsigned m_os_cnt = 0;
   bit m_pend = 1'b0;
   bit m_apply = 1'b0;
   bit exp_os = 1'b0, exp_tx = 1'b0, exp_done = 1'b0, exp_err = 1'b0;

   uart_baud_sched dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_en        (i_en),
      .i_cfg_div   (i_cfg_div),
      .i_cfg_valid (i_cfg_valid),
      .o_cfg_ready (o_cfg_ready),
      .o_cfg_done  (o_cfg_done),
      .o_cfg_err   (o_cfg_err),
      .i_tx_busy   (i_tx_busy),
      .i_rx_busy   (i_rx_busy),
      .i_tx_sync   (i_tx_sync),
      .o_os_tick   (o_os_tick),
      .o_tx_tick   (o_tx_tick),
      .o_div       (o_div)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_div = 27; m_pend_div = 0; m_elapsed = 0; m_os_cnt = 0;
      m_pend = 1'b0; m_apply = 1'b0;
      exp_os = 1'b0; exp_tx = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
   endtask

   task automatic model_edge();
      bit wrap;
      exp_os = 1'b0; exp_tx = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
      if (m_apply) begin
         m_div = m_pend_div; m_elapsed = 0; m_os_cnt = 0;
         m_apply = 1'b0; m_pend = 1'b0; exp_done = 1'b1;
         return;
      end
      if (m_pend) begin
         if (!i_tx_busy && !i_rx_busy) m_apply = 1'b1;
      end else if (i_cfg_valid) begin
         if (i_cfg_div < 2) exp_err = 1'b1;
         else begin m_pend = 1'b1; m_pend_div = i_cfg_div; end
      end
      if (!i_en) begin
         m_elapsed = 0; m_os_cnt = 0;
      end else begin
         m_elapsed++;
         wrap = (m_elapsed == m_div);
         if (wrap) begin m_elapsed = 0; exp_os = 1'b1; end
         if (i_tx_sync) m_os_cnt = 0;
         else if (wrap) begin
            m_os_cnt++;
            if (m_os_cnt == 16) begin exp_tx = 1'b1; m_os_cnt = 0; end
         end
      end
   endtask

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) model_reset();
      else model_edge();
   end

   always @(negedge i_clk) begin
      if (chk_on) begin
         chk("os_tick", o_os_tick, exp_os);
         chk("tx_tick", o_tx_tick, exp_tx);
         chk("cfg_done", o_cfg_done, exp_done);
         chk("cfg_err", o_cfg_err, exp_err);
         chk("cfg_ready", o_cfg_ready, !m_pend && !m_apply);
         chk("div", o_div, m_div);
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic cfg_req(input int unsigned d);
      i_cfg_valid = 1'b1;
      i_cfg_div = 16'(d);
      tick();
      i_cfg_valid = 1'b0;
   endtask

   initial begin
      int first_os, first_tx, c, gap;
      bit found;

      // Reset state
      #1 i_rst_n = 1'b0;
      chk_on = 1'b1;
      tick(); tick();
      chk("rst_ready", o_cfg_ready, 1);
      chk("rst_div", o_div, 27);
      chk("rst_os", o_os_tick, 0);
      chk("rst_done", o_cfg_done, 0);
      i_en = 1'b1;
      i_rst_n = 1'b1;

      // Default rate: first os tick at 27, first tx tick at 432, then every 432
      first_os = 0; first_tx = 0;
      for (int k = 1; k <= 1000; k++) begin
         @(posedge i_clk); #1;
         if (o_os_tick && first_os == 0) first_os = k;
         if (o_tx_tick) begin first_tx = k; break; end
      end
      chk("first_os_cycle", first_os, 27);
      chk("first_tx_cycle", first_tx, 432);
      gap = 0;
      for (int k = 1; k <= 1000; k++) begin
         @(posedge i_clk); #1;
         if (o_tx_tick) begin gap = k; break; end
      end
      chk("tx_period_27", gap, 432);
      #1;

      // Divisor 10 with both engines idle
      cfg_req(10);
      chk("acc_ready_low", o_cfg_ready, 0);
      chk("acc_done_early", o_cfg_done, 0);
      tick();
      chk("apply_done_early", o_cfg_done, 0);
      tick();
      chk("done_at_2", o_cfg_done, 1);
      chk("div_10", o_div, 10);
      for (int k = 1; k <= 400; k++) begin
         @(posedge i_clk); #1;
         if (o_tx_tick) break;
      end
      gap = 0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge i_clk); #1;
         if (o_tx_tick) begin gap = k; break; end
      end
      chk("tx_period_10", gap, 160);
      #1;

      // Divisor 8 while RX busy; a second request must be ignored
      i_rx_busy = 1'b1;
      cfg_req(8);
      repeat (100) tick();
      cfg_req(5);
      repeat (400) tick();
      chk("pend_div_old", o_div, 10);
      chk("pend_ready_low", o_cfg_ready, 0);
      i_rx_busy = 1'b0;
      tick();
      chk("busy_fall_done_early", o_cfg_done, 0);
      tick();
      chk("busy_fall_done", o_cfg_done, 1);
      chk("div_8", o_div, 8);

      // Illegal divisors
      cfg_req(1);
      chk("err_div1", o_cfg_err, 1);
      chk("err_div1_ready", o_cfg_ready, 1);
      cfg_req(0);
      chk("err_div0", o_cfg_err, 1);
      repeat (3) tick();
      chk("err_div_kept", o_div, 8);

      // TX sync on a wrap edge at phase 7
      found = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (m_elapsed == m_div - 1 && m_os_cnt == 7) begin found = 1'b1; break; end
         tick();
      end
      chk("sync_point_found", found, 1);
      i_tx_sync = 1'b1;
      tick();
      i_tx_sync = 1'b0;
      chk("sync_os_tick", o_os_tick, 1);
      chk("sync_no_tx", o_tx_tick, 0);
      gap = 0;
      for (int k = 1; k <= 1000; k++) begin
         @(posedge i_clk); #1;
         if (o_tx_tick) begin gap = k; break; end
      end
      chk("sync_tx_gap", gap, 16 * 8);
      #1;

      // Disable, then reset during a pending request
      i_en = 1'b0;
      c = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (o_os_tick || o_tx_tick) c++;
      end
      chk("disabled_ticks", c, 0);
      i_en = 1'b1;
      i_tx_busy = 1'b1;
      cfg_req(6);
      repeat (5) tick();
      i_rst_n = 1'b0;
      tick();
      chk("rst_pend_div", o_div, 27);
      chk("rst_pend_ready", o_cfg_ready, 1);
      i_rst_n = 1'b1;
      i_tx_busy = 1'b0;
      c = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (o_cfg_done) c++;
      end
      chk("rst_pend_no_done", c, 0);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         i_cfg_valid = ($urandom_range(0, 7) == 0);
         i_cfg_div   = 16'($urandom_range(0, 12));
         if ($urandom_range(0, 15) == 0) i_tx_busy = ~i_tx_busy;
         if ($urandom_range(0, 15) == 0) i_rx_busy = ~i_rx_busy;
         i_tx_sync   = ($urandom_range(0, 39) == 0);
         i_en        = ($urandom_range(0, 59) != 0);
         tick();
      end
      i_cfg_valid = 1'b0; i_tx_sync = 1'b0; i_en = 1'b1;
      tick(); tick();
      chk_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
